// File: rtl/op_select_pkg.sv
// Shared definitions for the calculator operator-select front end.
// Purely combinational helpers, no latency.
// No flow control lives here.
package op_select_pkg;

  // LCD character codes
  localparam logic [7:0] LCD_BLANK   = 8'h20;
  localparam logic [7:0] LCD_UNKNOWN = 8'h3F;
  localparam logic [7:0] LCD_PLUS    = 8'h2B;
  localparam logic [7:0] LCD_MINUS   = 8'h2D;
  localparam logic [7:0] LCD_TIMES   = 8'hD7;
  localparam logic [7:0] LCD_SLASH   = 8'h2F;
  localparam logic [7:0] LCD_OBELUS  = 8'hF7;
  localparam logic [7:0] LCD_CARET   = 8'h5E;
  localparam logic [7:0] LCD_BANG    = 8'h21;
  localparam logic [7:0] LCD_EQUALS  = 8'h3D;

  // Operator-select FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Map an operator index to its LCD glyph; unknown operators show '?'
  function automatic logic [7:0] op_char(input logic [31:0] code);
    logic [7:0] ch;
    case (code)
      32'd0:   ch = LCD_PLUS;
      32'd1:   ch = LCD_MINUS;
      32'd2:   ch = LCD_TIMES;
      32'd3:   ch = LCD_SLASH;
      32'd4:   ch = LCD_OBELUS;
      32'd5:   ch = LCD_CARET;
      32'd6:   ch = LCD_BANG;
      32'd7:   ch = LCD_EQUALS;
      default: ch = LCD_UNKNOWN;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/op_select_debounce_sw_debounce.sv
// Synchronises and debounces a vector of mechanical switches.
// Latency: 2 clk sync + up to DB_TICKS+1 sample ticks to update db.
// No backpressure: db is a level output that simply follows stable input.
module sw_debounce #(
  parameter int N_SW     = 8,
  parameter int TICK_DIV = 500000,
  parameter int DB_TICKS = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] db
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DB_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DB_TICKS);
  localparam logic [CW-1:0] CNT_PRE   = CW'(DB_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [N_SW-1:0] sync_q1;
  logic [N_SW-1:0] sync_q2;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [N_SW-1:0] last_smp;
  logic [CW-1:0]   stable_cnt;

  // Two-flop synchroniser; the raw asynchronous input feeds nothing else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= sw_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Free-running sample divider, tick fires on the wrap cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_ONE;
    end
  end

  // Count consecutive equal samples; publish the vector once it has held DB_TICKS times
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_smp   <= '0;
      stable_cnt <= '0;
      db         <= '0;
    end else if (tick) begin
      if (sync_q2 == last_smp) begin
        if (stable_cnt != CNT_MAX) begin
          stable_cnt <= stable_cnt + CNT_ONE;
          if (stable_cnt == CNT_PRE) begin
            db <= last_smp;
          end
        end
      end else begin
        last_smp   <= sync_q2;
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/op_select_debounce.sv
// Operator-select front end: debounced switches -> one-shot operator + LCD/LED display.
// Latency: 1 clk from a debounced one-hot vector to o_op_valid.
// o_op_valid holds with a frozen code until i_op_ready; each press is issued once.
module op_select_debounce
  import op_select_pkg::*;
#(
  parameter int N_SW     = 8,
  parameter int TICK_DIV = 500000,
  parameter int DB_TICKS = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SW-1:0]         i_sw_dip,
  input  logic                    i_clr,
  input  logic                    i_op_ready,
  output logic                    o_op_valid,
  output logic [$clog2(N_SW)-1:0] o_op_code,
  output logic [N_SW-1:0]         o_led,
  output logic [7:0]              o_lcd_char,
  output logic                    o_multi_err
);

  localparam int CW = $clog2(N_SW);
  localparam logic [N_SW-1:0] DB_ONE = N_SW'(1);

  logic [N_SW-1:0] db;
  logic [CW-1:0]   sel_code;
  logic            db_zero;
  logic            one_hot;
  logic            multi_hot;
  state_t          state;

  sw_debounce #(
    .N_SW     (N_SW),
    .TICK_DIV (TICK_DIV),
    .DB_TICKS (DB_TICKS)
  ) u_sw_debounce (
    .clk    (clk),
    .rst    (rst),
    .sw_raw (i_sw_dip),
    .db     (db)
  );

  // Classify the debounced vector and find the operator index (MSB switch is operator 0)
  always_comb begin
    sel_code  = '0;
    db_zero   = (db == '0);
    one_hot   = !db_zero && ((db & (db - DB_ONE)) == '0);
    multi_hot = !db_zero && !one_hot;
    for (int i = 0; i < N_SW; i++) begin
      if (db[N_SW-1-i]) begin
        sel_code = CW'(i);
      end
    end
  end

  // Selection FSM with registered handshake and display outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      o_op_valid  <= 1'b0;
      o_op_code   <= '0;
      o_led       <= '0;
      o_lcd_char  <= LCD_BLANK;
      o_multi_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (one_hot) begin
            // A fresh capture takes priority over a same-cycle clear
            o_op_code  <= sel_code;
            o_led      <= db;
            o_lcd_char <= op_char(32'(sel_code));
            o_op_valid <= 1'b1;
            state      <= ST_PEND;
          end else if (multi_hot) begin
            o_multi_err <= 1'b1;
            o_led       <= '0;
            o_lcd_char  <= LCD_BLANK;
            state       <= ST_RELEASE;
          end else if (i_clr) begin
            o_led       <= '0;
            o_lcd_char  <= LCD_BLANK;
            o_multi_err <= 1'b0;
          end
        end

        ST_PEND: begin
          // Code stays frozen here whatever the switches do
          if (o_op_valid && i_op_ready) begin
            o_op_valid <= 1'b0;
            state      <= ST_RELEASE;
          end else if (i_clr) begin
            o_op_valid <= 1'b0;
            state      <= ST_RELEASE;
          end
          if (i_clr) begin
            o_led       <= '0;
            o_lcd_char  <= LCD_BLANK;
            o_multi_err <= 1'b0;
          end
        end

        ST_RELEASE: begin
          // Require a debounced all-off before the next selection: no auto-repeat
          if (db_zero) begin
            o_multi_err <= 1'b0;
            state       <= ST_IDLE;
          end
          if (i_clr) begin
            o_led       <= '0;
            o_lcd_char  <= LCD_BLANK;
            o_multi_err <= 1'b0;
          end
        end

        default: begin
          o_op_valid <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_op_select_debounce.sv
// Directed and randomized checks of op_select_debounce against a segment-level model.
// Inputs change and outputs are sampled on the falling clock edge.
// Transfers are logged on the rising edge whenever valid and ready are both high.
module tb_op_select_debounce;

  localparam int N_SW     = 8;
  localparam int TICK_DIV = 4;
  localparam int DB_TICKS = 3;

  logic       clk;
  logic       rst;
  logic [7:0] sw;
  logic       clr;
  logic       ready;
  logic       valid;
  logic [2:0] code;
  logic [7:0] led;
  logic [7:0] lcd;
  logic       err;

  int n_assert = 0;
  int n_fail   = 0;
  int xfer_cnt = 0;
  int exp_x    = 0;
  int got_codes[$];
  int exp_codes[$];

  op_select_debounce #(
    .N_SW     (N_SW),
    .TICK_DIV (TICK_DIV),
    .DB_TICKS (DB_TICKS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sw_dip    (sw),
    .i_clr       (clr),
    .i_op_ready  (ready),
    .o_op_valid  (valid),
    .o_op_code   (code),
    .o_led       (led),
    .o_lcd_char  (lcd),
    .o_multi_err (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer log
  always @(posedge clk) begin
    if (rst && valid && ready) begin
      xfer_cnt = xfer_cnt + 1;
      got_codes.push_back(int'(code));
    end
  end

  function automatic logic [7:0] glyph(input int c);
    logic [7:0] tbl [8];
    tbl = '{8'h2B, 8'h2D, 8'hD7, 8'h2F, 8'hF7, 8'h5E, 8'h21, 8'h3D};
    return (c >= 0 && c < 8) ? tbl[c] : 8'h3F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(valid), 32'd1);
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic chk_disp(input string tag, input int c, input logic [7:0] l);
    chk({tag, "_code"}, 32'(code), 32'(c));
    chk({tag, "_lcd"}, 32'(lcd), 32'(glyph(c)));
    chk({tag, "_led"}, 32'(led), 32'(l));
  endtask

  initial begin
    int m_st;   // 0 waiting for a selection, 1 operator pending, 2 waiting for all-off
    int m_code;
    logic       m_err;
    logic [7:0] m_led;
    logic [7:0] m_char;
    logic [7:0] v;
    logic       r;
    logic       saw_valid;
    int b1;
    int b2;

    rst   = 1'b0;
    sw    = 8'h80;
    clr   = 1'b0;
    ready = 1'b0;

    // Reset state with a switch already held
    cyc(5);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_led", 32'(led), 32'h00);
    chk("rst_lcd", 32'(lcd), 32'h20);
    chk("rst_code", 32'(code), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Held switch is accepted after reset within the debounce latency
    rst = 1'b1;
    wait_valid("rst_press_latency", 18);
    chk_disp("rst_press", 0, 8'h80);
    pulse_ready();
    exp_x++;
    chk("rst_press_drop", 32'(valid), 32'd0);
    cyc(30);
    chk("rst_press_once", 32'(xfer_cnt), 32'(exp_x));
    chk("rst_press_novalid", 32'(valid), 32'd0);
    sw = 8'h00;
    cyc(30);

    // Bouncing input never produces an operator
    saw_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      sw = (i % 2 == 0) ? 8'h10 : 8'h00;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (valid) saw_valid = 1'b1;
      end
    end
    chk("bounce_no_valid", 32'(saw_valid), 32'd0);
    sw = 8'h10;
    wait_valid("bounce_settle", 30);
    chk_disp("bounce", 3, 8'h10);
    pulse_ready();
    exp_x++;
    sw = 8'h00;
    cyc(30);

    // Back-pressure: code frozen while switches change, single transfer, no repeat
    sw = 8'h04;
    wait_valid("bp_valid", 30);
    chk_disp("bp", 5, 8'h04);
    cyc(10);
    sw = 8'h01;
    cyc(40);
    chk("bp_hold_valid", 32'(valid), 32'd1);
    chk_disp("bp_hold", 5, 8'h04);
    pulse_ready();
    exp_x++;
    chk("bp_xfer", 32'(xfer_cnt), 32'(exp_x));
    cyc(40);
    chk("bp_no_repeat", 32'(valid), 32'd0);
    chk("bp_no_repeat_cnt", 32'(xfer_cnt), 32'(exp_x));
    sw = 8'h00;
    cyc(30);
    sw = 8'h01;
    wait_valid("bp_next", 30);
    chk_disp("bp_next", 7, 8'h01);
    pulse_ready();
    exp_x++;
    sw = 8'h00;
    cyc(30);

    // Multi-hot selection flags an error and is never issued
    sw = 8'h81;
    cyc(30);
    chk("multi_err", 32'(err), 32'd1);
    chk("multi_valid", 32'(valid), 32'd0);
    chk("multi_lcd", 32'(lcd), 32'h20);
    chk("multi_led", 32'(led), 32'h00);
    chk("multi_cnt", 32'(xfer_cnt), 32'(exp_x));
    sw = 8'h00;
    cyc(30);
    chk("multi_err_clear", 32'(err), 32'd0);
    sw = 8'h02;
    wait_valid("multi_next", 30);
    chk_disp("multi_next", 6, 8'h02);
    pulse_ready();
    exp_x++;
    sw = 8'h00;
    cyc(30);

    // Clear while pending discards the operator
    sw = 8'h40;
    wait_valid("clr_valid", 30);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_valid_drop", 32'(valid), 32'd0);
    chk("clr_led", 32'(led), 32'h00);
    chk("clr_lcd", 32'(lcd), 32'h20);
    chk("clr_no_xfer", 32'(xfer_cnt), 32'(exp_x));
    sw = 8'h00;
    cyc(30);

    // Clear together with ready: transfer still completes, display blanks
    sw = 8'h20;
    wait_valid("clr_rdy_valid", 30);
    chk("clr_rdy_lcd_before", 32'(lcd), 32'hD7);
    clr   = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    clr   = 1'b0;
    ready = 1'b0;
    exp_x++;
    chk("clr_rdy_xfer", 32'(xfer_cnt), 32'(exp_x));
    chk("clr_rdy_lcd", 32'(lcd), 32'h20);
    chk("clr_rdy_led", 32'(led), 32'h00);
    chk("clr_rdy_valid", 32'(valid), 32'd0);
    sw = 8'h00;
    cyc(30);

    // Asynchronous reset pulse in the middle of a pending handshake
    sw = 8'h08;
    wait_valid("arst_valid", 30);
    chk_disp("arst_before", 4, 8'h08);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_led", 32'(led), 32'h00);
    chk("arst_lcd", 32'(lcd), 32'h20);
    chk("arst_code", 32'(code), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_lost", 32'(xfer_cnt), 32'(exp_x));
    wait_valid("arst_reissue", 30);
    chk_disp("arst_reissue", 4, 8'h08);
    pulse_ready();
    exp_x++;
    sw = 8'h00;
    cyc(30);
    chk("directed_xfer_total", 32'(xfer_cnt), 32'(exp_x));

    // Randomized segments, each long enough for the switches to settle
    got_codes.delete();
    m_st   = 0;
    m_err  = 1'b0;
    m_led  = 8'h08;
    m_char = 8'hF7;
    m_code = 4;
    for (int seg = 0; seg < 20; seg++) begin
      case ($urandom_range(0, 2))
        0: v = 8'h00;
        1: v = 8'h01 << $urandom_range(0, 7);
        default: begin
          b1 = int'($urandom_range(0, 7));
          b2 = (b1 + 1 + int'($urandom_range(0, 6))) % 8;
          v  = (8'h01 << b1) | (8'h01 << b2);
        end
      endcase
      r = 1'($urandom_range(0, 1));
      sw    = v;
      ready = r;
      cyc(40);

      // Reference: a waiting operator leaves first, then the new stable vector takes effect
      if (m_st == 1 && r) begin
        exp_codes.push_back(m_code);
        exp_x++;
        m_st = 2;
      end
      if (m_st == 2 && v == 8'h00) begin
        m_st  = 0;
        m_err = 1'b0;
      end else if (m_st == 0 && v != 8'h00) begin
        if ($countones(v) == 1) begin
          m_st   = 1;
          m_code = 7 - $clog2(int'(v));
          m_led  = v;
          m_char = glyph(m_code);
        end else begin
          m_st   = 2;
          m_err  = 1'b1;
          m_led  = 8'h00;
          m_char = 8'h20;
        end
      end
      if (m_st == 1 && r) begin
        exp_codes.push_back(m_code);
        exp_x++;
        m_st = 2;
      end

      chk("rand_valid", 32'(valid), 32'(m_st == 1));
      chk("rand_err", 32'(err), 32'(m_err));
      chk("rand_led", 32'(led), 32'(m_led));
      chk("rand_lcd", 32'(lcd), 32'(m_char));
      chk("rand_xfer", 32'(xfer_cnt), 32'(exp_x));
      if (m_st == 1) chk("rand_code", 32'(code), 32'(m_code));
    end
    ready = 1'b0;

    chk("rand_log_len", 32'(got_codes.size()), 32'(exp_codes.size()));
    for (int i = 0; i < exp_codes.size() && i < got_codes.size(); i++) begin
      chk("rand_log_code", 32'(got_codes[i]), 32'(exp_codes[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/op_select_debounce.md
Name: op_select_debounce

Overview:
- Parametrised operator-select front end for the calculator.
- Samples N_SW DIP/push switches, synchronises and debounces them, and validates that exactly one switch is on.
- Issues each accepted operator once to the calculator core over a valid/ready handshake.
- Drives LEDs and an 8-bit LCD character code for the current operator; multi-switch selections are flagged as errors and never issued.

Parameters:
- N_SW, 8, number of operator switches (2..16); bit N_SW-1 is operator 0.
- TICK_DIV, 500000, clk cycles per sample tick (100 Hz at 50 MHz); minimum 2.
- DB_TICKS, 3, consecutive equal samples required to accept a switch vector; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_sw_dip  in  N_SW  raw asynchronous switch inputs.
- i_clr  in  1  synchronous clear of display and pending operator.
- i_op_ready  in  1  core accepts the operator.
- o_op_valid  out  1  operator available.
- o_op_code  out  clog2(N_SW)  operator index, 0 = MSB switch.
- o_led  out  N_SW  one-hot image of the displayed operator.
- o_lcd_char  out  8  LCD character for the displayed operator.
- o_multi_err  out  1  more than one switch was on.

Behaviour:
- Reset (rst=0, async): all flops clear. o_op_valid=0, o_op_code=0, o_led=0, o_lcd_char=0x20, o_multi_err=0, state IDLE, tick counter 0, debounced vector 0.
- Synchroniser: 2-flop chain on i_sw_dip; no other logic touches the raw input.
- Tick: counter 0..TICK_DIV-1; tick pulses 1 cycle at wrap.
- Debounce, on each tick:
  - If sync == last sample, the stable count increments, saturating at DB_TICKS.
  - Otherwise, last sample <= sync and count <= 0.
  - When the count first reaches DB_TICKS, db <= last sample.
  - Latency from an input change to a db update: 2 cycles sync, then DB_TICKS+1 ticks worst case.
- Character table, by code:
  - 0 '+' 0x2B, 1 '-' 0x2D, 2 0xD7, 3 '/' 0x2F.
  - 4 0xF7, 5 '^' 0x5E, 6 '!' 0x21, 7 '=' 0x3D.
  - Codes 8 and above: '?' 0x3F. Blank: 0x20.
- FSM states IDLE, PEND, RELEASE:
  - IDLE:
    - db == 0: stay.
    - db one-hot: capture o_op_code, o_led=db, o_lcd_char=table[code], o_op_valid=1 (next cycle), go PEND.
    - db multi-hot: o_multi_err=1, o_led=0, o_lcd_char=0x20, go RELEASE.
  - PEND:
    - o_op_valid=1; o_op_code frozen regardless of db changes.
    - o_op_valid && i_op_ready: o_op_valid=0 next cycle, go RELEASE; display is held.
  - RELEASE:
    - Wait for db == 0, then go IDLE and clear o_multi_err on that transition.
    - A new selection requires a debounced all-off first, so there is no auto-repeat.
- i_clr:
  - Any state: o_led=0, o_lcd_char=0x20, o_multi_err=0.
  - In PEND: additionally o_op_valid=0, go RELEASE (operator discarded).
  - In IDLE on a same-cycle capture: the capture wins; i_clr is ignored.
  - In PEND with i_op_ready in the same cycle: the handshake completes (transfer counted) and the display is cleared.
- i_op_ready outside PEND is ignored.
- Reset mid-handshake: o_op_valid drops immediately (async); the operator is lost.
- Switch held through reset: after reset, debounce accepts it as a new press and issues it once.

Decomposition:
- Package op_select_pkg:
  - LCD character constants: blank, '?', the 8 operator codes.
  - Function code->char.
  - FSM state enum.
- Sub-module sw_debounce: synchroniser, tick counter, and stable counter; outputs db[N_SW-1:0].
- The parent holds the FSM, one-hot check, and display registers.

Test Plan (TICK_DIV=4, DB_TICKS=3, N_SW=8):
- Reset: rst low, switches 0x80 -> o_led=0, o_lcd_char=0x20, o_op_valid=0. Release reset, hold 0x80 -> o_op_valid=1, o_op_code=0, o_lcd_char=0x2B within 2+16 cycles; exactly one transfer.
- Bounce: toggle 0x10/0x00 every 3 cycles for 40 cycles, then hold 0x10 -> no valid during toggling; then o_op_code=3, o_lcd_char=0x2F, o_led=0x10.
- Back-pressure: select 0x04 with i_op_ready=0 for 50 cycles, change switches to 0x01 -> valid held, code stays 5 (0x5E); ready=1 gives one transfer; no further valid until switches read 0 and then 0x01 (code 7, 0x3D).
- Multi-hot: hold 0x81 -> o_multi_err=1, o_op_valid never asserts, o_lcd_char=0x20; go to 0x00 then 0x02 -> err clears, code 6 issued (0x21).
- Clear: i_clr during PEND -> valid drops next cycle, display blank, no transfer. i_clr together with i_op_ready -> transfer counted, display blank.
- Async reset mid-PEND: pulse rst low for 1 ns between clock edges -> o_op_valid=0 immediately; all outputs at reset values.
